// File: rtl/mux_scan_sequencer.sv
// Clocked scan front-end for an 8:1 single-bit mux: steps the select through
// channels 0..7, samples the mux output after a settle delay, and emits a byte.
module mux_scan_sequencer #(
    parameter int unsigned SETTLE_CYC = 1,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       mux_out,
    output logic [2:0] sel,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [1:0] fsm_state
);

    // Output handshake: a word transfers on a rising edge where out_valid and
    // out_ready are both high; while out_valid is high and out_ready is low,
    // out_data and out_valid hold. out_valid never depends on out_ready.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYC);
    // With no settle time a channel is a single SAMPLE cycle.
    localparam state_t FIRST = (SETTLE_CYC == 0) ? SAMPLE : WAIT;

    state_t     state;
    logic [3:0] settle_cnt;
    logic [6:0] shadow;

    assign fsm_state = state;

    // sel doubles as the channel index while scanning; it is 0 in IDLE/DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= 3'd0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 8'd0;
            shadow     <= 7'd0;
            settle_cnt <= 4'd0;
        end else if (abort && state != IDLE) begin
            state      <= IDLE;
            sel        <= 3'd0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            shadow     <= 7'd0;
            settle_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state      <= FIRST;
                        sel        <= 3'd0;
                        busy       <= 1'b1;
                        settle_cnt <= SETTLE;
                    end
                end
                WAIT: begin
                    if (settle_cnt <= 4'd1) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    if (sel != 3'd7) begin
                        shadow[sel] <= mux_out;
                        sel         <= sel + 3'd1;
                        settle_cnt  <= SETTLE;
                        state       <= FIRST;
                    end else begin
                        // Last channel goes straight into the word, not the shadow.
                        out_data  <= {mux_out, shadow};
                        out_valid <= 1'b1;
                        sel       <= 3'd0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (CONTINUOUS || start) begin
                            state      <= FIRST;
                            sel        <= 3'd0;
                            settle_cnt <= SETTLE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
